counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Command sequencer in front of the 8-bit latch/div/dec counter. Accepts one command per handshake
//  (LOAD, DIV, DEC, RUN_DOWN), legality-checks it against the live count, and drives the counter strobes.
//  Reports completion with result, step count and error flag. Sits between a bus/CPU command source
//  and the counter datapath.
// PARAMETERS
//  WIDTH      8    data width of counter, cmd_arg, result
//  STEP_W     8    width of steps output
//  MAX_STEPS  255  RUN_DOWN step limit; reaching it ends the command with err
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       controller idle, can accept
//  cmd_op     in   2       0=LOAD 1=DIV 2=DEC 3=RUN_DOWN
//  cmd_arg    in   WIDTH   operand
//  abort      in   1       stop an active RUN_DOWN
//  busy       out  1       command in progress
//  done       out  1       one-cycle completion pulse
//  err        out  1       valid with done: command rejected, aborted or timed out
//  result     out  WIDTH   ctr_count at completion; valid with done, held until next done
//  steps      out  STEP_W  decrements issued by last command; held until next done
//  ctr_in     out  WIDTH   counter operand; =arg while a strobe is high, else 0
//  ctr_latch  out  1       counter load strobe
//  ctr_div    out  1       counter divide strobe
//  ctr_dec    out  1       counter decrement strobe
//  ctr_count  in   WIDTH   live counter value
//  ctr_zero   in   1       counter == 0
// BEHAVIOUR
//  Counter contract, per rising edge:
//   latch: count<=in; div: count<=count/in; dec: count<=count-in. Exactly one strobe is ever high.
//  Reset: state IDLE; cmd_ready=1; all other outputs 0. All strobes drop immediately (async).
//  cmd_ready=1 only in IDLE. Handshake = cmd_valid&&cmd_ready in cycle T; op/arg are registered.
//  Inputs are ignored while busy. busy=1 from T+1 until done is high.
//  States: IDLE -> EXEC -> SETTLE -> DONE -> IDLE. RUN_DOWN loops EXEC/SETTLE.
//  EXEC (T+1) checks legality against ctr_count. Illegal cases:
//   DIV with arg==0; DEC with arg>ctr_count; RUN_DOWN with arg==0.
//  Illegal command: no strobe; DONE in T+2 with done=1, err=1, steps=0, result=ctr_count.
//  Legal single op: one strobe in T+1 with ctr_in=arg; SETTLE in T+2.
//   DONE in T+3: done=1, err=0, result=updated count, steps=1 for DEC, else 0. IDLE/cmd_ready at T+4.
//  RUN_DOWN: each EXEC issues a dec strobe if ctr_count>=arg and !ctr_zero, then SETTLE; else go to DONE.
//   One decrement per 2 cycles.
//   Normal end: err=0, result=remainder (ctr_count<arg, may be 0), steps=decrements issued.
//   abort sampled high in any RUN_DOWN cycle: finish the current SETTLE, then DONE with err=1;
//    no further strobe is issued.
//   After a step, if steps==MAX_STEPS and ctr_count>=arg (more work pending): DONE with err=1.
//   Reaching exactly 0 at MAX_STEPS is a normal end.
//  abort is ignored outside RUN_DOWN. Mid-command reset aborts it silently: no done pulse.
//  steps saturates at 2^STEP_W-1.
// TESTING
//  1 LOAD 16 -> T+1 ctr_latch=1, ctr_in=16 for one cycle; T+3 done=1, result=16, err=0; T+4 cmd_ready=1.
//  2 after 1, DIV 2 -> result=8. DIV 0 -> no strobe, done+err at T+2, result=8.
//  3 count=8, DEC 9 -> err, no strobe, result=8. DEC 3 -> result=5, steps=1.
//  4 LOAD 23, RUN_DOWN 5 -> 4 dec strobes on alternate cycles; result=3, steps=4, err=0.
//    LOAD 20, RUN_DOWN 5 -> result=0, steps=4.
//  5 LOAD 200, RUN_DOWN 1, abort after 2nd strobe -> err=1, steps=2, result=198.
//    MAX_STEPS=3: same command without abort -> err=1, steps=3, result=197.
//  6 reset asserted mid RUN_DOWN while ctr_dec=1 -> strobe low same cycle; no done;
//    cmd_ready=1 after release; next LOAD 7 -> result=7.

Source files
------------

// File: rtl/counter_ctrl.sv
// Command sequencer for the 8-bit latch/div/dec counter: accepts LOAD/DIV/DEC/RUN_DOWN,
// legality-checks against the live count, drives one counter strobe at a time and reports completion.
module counter_ctrl #(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_arg,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  result,
  output logic [STEP_W-1:0] steps,
  output logic [WIDTH-1:0]  ctr_in,
  output logic              ctr_latch,
  output logic              ctr_div,
  output logic              ctr_dec,
  input  logic [WIDTH-1:0]  ctr_count,
  input  logic              ctr_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SETTLE, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_DIV, OP_DEC, OP_RUN} op_t;

  state_t            r_state;
  state_t            w_state_next;
  op_t               r_op;
  logic [WIDTH-1:0]  r_arg;
  logic [STEP_W-1:0] r_step_cnt;
  logic [WIDTH-1:0]  r_result;
  logic [STEP_W-1:0] r_steps;
  logic              r_err;
  logic              w_latch;
  logic              w_div;
  logic              w_dec;
  logic              w_fail;
  logic              w_accept;
  logic              w_at_limit;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_at_limit = (r_step_cnt == STEP_W'(MAX_STEPS));

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_div        = 1'b0;
    w_dec        = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        case (r_op)
          OP_LOAD: begin
            w_latch      = 1'b1;
            w_state_next = S_SETTLE;
          end
          OP_DIV: begin
            if (r_arg == '0) begin
              w_fail       = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_div        = 1'b1;
              w_state_next = S_SETTLE;
            end
          end
          OP_DEC: begin
            if (r_arg > ctr_count) begin
              w_fail       = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_dec        = 1'b1;
              w_state_next = S_SETTLE;
            end
          end
          default: begin
            // An abort seen here suppresses this cycle's strobe outright
            if ((r_arg == '0) || abort) begin
              w_fail       = 1'b1;
              w_state_next = S_DONE;
            end else if ((ctr_count >= r_arg) && !ctr_zero) begin
              w_dec        = 1'b1;
              w_state_next = S_SETTLE;
            end else begin
              w_state_next = S_DONE;
            end
          end
        endcase
      end
      S_SETTLE: begin
        if (r_op == OP_RUN) begin
          if (abort || (w_at_limit && (ctr_count >= r_arg))) begin
            w_fail       = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_EXEC;
          end
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_LOAD;
      r_arg      <= '0;
      r_step_cnt <= '0;
      r_result   <= '0;
      r_steps    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op       <= op_t'(cmd_op);
        r_arg      <= cmd_arg;
        r_step_cnt <= '0;
      end else if (w_dec && (r_step_cnt != '1)) begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
      // Completion values are captured on the edge entering DONE and held until the next one
      if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
        r_result <= ctr_count;
        r_steps  <= r_step_cnt;
        r_err    <= w_fail;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = done && r_err;
  assign result    = r_result;
  assign steps     = r_steps;
  assign ctr_latch = w_latch;
  assign ctr_div   = w_div;
  assign ctr_dec   = w_dec;
  assign ctr_in    = (w_latch || w_div || w_dec) ? r_arg : '0;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: two instances (default limit and MAX_STEPS=3) each driving a behavioural counter.
module tb_counter_ctrl;

  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;

  logic       valid_a, ready_a, busy_a, done_a, err_a, latch_a, div_a, dec_a, zero_a;
  logic [7:0] result_a, steps_a, ctr_in_a;
  logic [7:0] cnt_a = 8'd0;
  logic       valid_b, ready_b, busy_b, done_b, err_b, latch_b, div_b, dec_b, zero_b;
  logic [7:0] result_b, steps_b, ctr_in_b;
  logic [7:0] cnt_b = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int mcount_a = 0;
  int mcount_b = 0;

  counter_ctrl u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .abort(abort), .busy(busy_a), .done(done_a), .err(err_a),
    .result(result_a), .steps(steps_a), .ctr_in(ctr_in_a), .ctr_latch(latch_a),
    .ctr_div(div_a), .ctr_dec(dec_a), .ctr_count(cnt_a), .ctr_zero(zero_a)
  );

  counter_ctrl #(.MAX_STEPS(MAX_B)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .abort(abort), .busy(busy_b), .done(done_b), .err(err_b),
    .result(result_b), .steps(steps_b), .ctr_in(ctr_in_b), .ctr_latch(latch_b),
    .ctr_div(div_b), .ctr_dec(dec_b), .ctr_count(cnt_b), .ctr_zero(zero_b)
  );

  // Counter datapath: latch / divide / decrement on the rising edge
  assign zero_a = (cnt_a == 8'd0);
  assign zero_b = (cnt_b == 8'd0);
  always @(posedge clk) begin
    if (latch_a) cnt_a <= ctr_in_a;
    else if (div_a && ctr_in_a != 8'd0) cnt_a <= cnt_a / ctr_in_a;
    else if (dec_a) cnt_a <= cnt_a - ctr_in_a;
    if (latch_b) cnt_b <= ctr_in_b;
    else if (div_b && ctr_in_b != 8'd0) cnt_b <= cnt_b / ctr_in_b;
    else if (dec_b) cnt_b <= cnt_b - ctr_in_b;
  end

  typedef struct packed {
    logic ready, busy, done, err, latch, div, dec;
    logic [7:0] result, steps, ctr_in;
  } snap_t;

  function automatic snap_t snap(input bit sel);
    snap_t s;
    if (sel) s = '{ready_b, busy_b, done_b, err_b, latch_b, div_b, dec_b, result_b, steps_b, ctr_in_b};
    else     s = '{ready_a, busy_a, done_a, err_a, latch_a, div_a, dec_a, result_a, steps_a, ctr_in_a};
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: outcome of one command computed from the counter value before it
  task automatic model(input int c, input int op, input int arg, input int maxs,
                       output int res, output int st, output int e, output int lat);
    res = c; st = 0; e = 0; lat = 3;
    case (op)
      0: res = arg;
      1: if (arg == 0) begin e = 1; lat = 2; end else res = c / arg;
      2: if (arg > c) begin e = 1; lat = 2; end else begin res = c - arg; st = 1; end
      default: begin
        if (arg == 0) begin
          e = 1; lat = 2;
        end else begin
          st = c / arg;
          if (st > maxs) begin st = maxs; e = 1; lat = 2 * maxs + 1; end
          else lat = 2 * st + 2;
          res = c - st * arg;
        end
      end
    endcase
  endtask

  // Issues one command at a negedge and watches it cycle by cycle until done.
  // abort_after>0: raise abort in the cycle after that many dec strobes; <0: hold abort throughout.
  task automatic do_cmd(input string name, input bit sel, input int op, input int arg,
                        input int abort_after, input int eres, input int est, input int ee,
                        input int elat);
    snap_t s;
    int viol = 0, nstb = 0, lat = 0, res = 0, st = 0, e = 0, last_stb = -5, nh, enstb;
    bit got = 1'b0, do_abort = 1'b0;
    s = snap(sel);
    if (!s.ready) viol++;
    abort   = (abort_after < 0);
    cmd_op  = 2'(op);
    cmd_arg = 8'(arg);
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      s  = snap(sel);
      nh = int'(s.latch) + int'(s.div) + int'(s.dec);
      if (s.done) begin
        got = 1'b1; lat = k; res = s.result; st = s.steps; e = s.err;
        if (nh != 0 || !s.busy) viol++;
        break;
      end
      if (!s.busy || s.ready || s.err) viol++;
      if (nh > 1) viol++;
      if (nh == 1) begin
        nstb++;
        if (s.ctr_in != 8'(arg)) viol++;
        if (k == last_stb + 1) viol++;
        last_stb = k;
        if (s.dec && abort_after > 0 && nstb == abort_after) do_abort = 1'b1;
      end else if (s.ctr_in != 8'd0) begin
        viol++;
      end
      @(negedge clk);
      if (do_abort) abort = 1'b1;
    end
    check({name, ".done_seen"}, int'(got), 1);
    @(negedge clk);
    abort = 1'b0;
    s = snap(sel);
    if (!s.ready || s.done || s.busy || int'(s.result) != res) viol++;
    enstb = (op == 3) ? est : (ee != 0 ? 0 : 1);
    $display("[TB] %s dut=%0d op=%0d arg=%0d -> result=%0d steps=%0d err=%0d latency=%0d strobes=%0d",
             name, sel, op, arg, res, st, e, lat, nstb);
    check({name, ".result"},  res,  eres);
    check({name, ".steps"},   st,   est);
    check({name, ".err"},     e,    ee);
    check({name, ".latency"}, lat,  elat);
    check({name, ".strobes"}, nstb, enstb);
    check({name, ".protocol"}, viol, 0);
    if (sel) mcount_b = eres; else mcount_a = eres;
  endtask

  typedef struct {
    int op, arg, res, st, e, lat;
  } vec_t;
  vec_t tbl[16];

  initial begin
    snap_t s;
    bit seen;
    int c, op, arg, eres, est, ee, elat;
    bit sel;

    tbl[0]  = '{0, 16, 16, 0, 0, 3};
    tbl[1]  = '{1, 2, 8, 0, 0, 3};
    tbl[2]  = '{1, 0, 8, 0, 1, 2};
    tbl[3]  = '{2, 9, 8, 0, 1, 2};
    tbl[4]  = '{2, 3, 5, 1, 0, 3};
    tbl[5]  = '{0, 23, 23, 0, 0, 3};
    tbl[6]  = '{3, 5, 3, 4, 0, 10};
    tbl[7]  = '{0, 20, 20, 0, 0, 3};
    tbl[8]  = '{3, 5, 0, 4, 0, 10};
    tbl[9]  = '{3, 0, 0, 0, 1, 2};
    tbl[10] = '{3, 3, 0, 0, 0, 2};
    tbl[11] = '{0, 255, 255, 0, 0, 3};
    tbl[12] = '{3, 1, 0, 255, 0, 512};
    tbl[13] = '{0, 100, 100, 0, 0, 3};
    tbl[14] = '{2, 100, 0, 1, 0, 3};
    tbl[15] = '{1, 1, 0, 0, 0, 3};

    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; abort = 1'b0;
    cmd_op = 2'd0; cmd_arg = 8'd0;
    #1;
    s = snap(1'b0);
    check("reset.ready", s.ready, 1);
    check("reset.busy", s.busy, 0);
    check("reset.done_err", {s.done, s.err}, 0);
    check("reset.result_steps", {s.result, s.steps}, 0);
    check("reset.strobes", {s.latch, s.div, s.dec, s.ctr_in}, 0);
    s = snap(1'b1);
    check("reset_b.outputs", {s.ready, s.busy, s.done, s.err, s.latch, s.div, s.dec}, 7'b1000000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      do_cmd($sformatf("vec%0d", i), 1'b0, tbl[i].op, tbl[i].arg, 0,
             tbl[i].res, tbl[i].st, tbl[i].e, tbl[i].lat);

    // Abort after the second decrement
    do_cmd("abort_load", 1'b0, 0, 200, 0, 200, 0, 0, 3);
    do_cmd("abort_run", 1'b0, 3, 1, 2, 198, 2, 1, 5);
    // Abort held high has no effect on non-RUN_DOWN commands
    do_cmd("abort_ign", 1'b0, 2, 8, -1, 190, 1, 0, 3);
    // Step limit of 3: pending work times out, landing exactly on 0 does not
    do_cmd("lim_load", 1'b1, 0, 200, 0, 200, 0, 0, 3);
    do_cmd("lim_run", 1'b1, 3, 1, 0, 197, 3, 1, 7);
    do_cmd("lim_load2", 1'b1, 0, 6, 0, 6, 0, 0, 3);
    do_cmd("lim_exact", 1'b1, 3, 2, 0, 0, 3, 0, 8);

    // Reset while a decrement strobe is high
    cmd_op = 2'd3; cmd_arg = 8'd1; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (dec_a) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid.dec_seen", int'(seen), 1);
    reset = 1'b1;
    #1;
    check("rst_mid.dec_drop", int'(dec_a), 0);
    check("rst_mid.ctr_in", int'(ctr_in_a), 0);
    check("rst_mid.ready", int'(ready_a), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_mid.no_done", int'(done_a), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid.ready_after", int'(ready_a), 1);
    check("rst_mid.done_after", int'(done_a), 0);
    do_cmd("post_rst", 1'b0, 0, 7, 0, 7, 0, 0, 3);

    // Random commands checked against the reference model
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      c   = sel ? mcount_b : mcount_a;
      op  = $urandom_range(0, 3);
      case (op)
        0:       arg = $urandom_range(0, 255);
        1:       arg = $urandom_range(0, 4);
        2:       arg = $urandom_range(0, (c > 250) ? 255 : c + 3);
        default: arg = $urandom_range(0, 20);
      endcase
      model(c, op, arg, sel ? MAX_B : 255, eres, est, ee, elat);
      do_cmd($sformatf("rnd%0d", i), sel, op, arg, 0, eres, est, ee, elat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
